// File: rtl/rs422_uart_rx.sv
// rs422_uart_rx: 8N1 UART receiver producing good-frame byte strobes plus frame/parity error strobes.
// Optional parity bit (8E1/8O1) is compiled in with `define RS422_UART_RX_PARITY_EN.
module rs422_uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       valid,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BIT_DIV);
  localparam logic [CW-1:0] MID = CW'(BIT_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;
  if (BIT_DIV < 16 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
    $error("rs422_uart_rx: BIT_DIV must be >= 16 and PARITY_ODD must be 0 or 1");
  end
  state_t state_q, state_d;
  logic sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [1:0] settle_q, settle_d;
  logic armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d, dout_q, dout_d;
  logic valid_q, valid_d, frame_err_q, frame_err_d, busy_q, busy_d;
`ifdef RS422_UART_RX_PARITY_EN
  logic par_q, par_d, parity_err_q, parity_err_d;
`endif
  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    hist_d = sync2_q;
    // The synchronizer holds reset values for two clocks; only a real high sample arms edge detection.
    settle_d = {settle_q[0], 1'b1};
    armed_d = armed_q | (settle_q[1] & sync2_q);
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    data_d = data_q;
    dout_d = dout_q;
    valid_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef RS422_UART_RX_PARITY_EN
    par_d = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (armed_q && hist_q && !sync2_q) begin
        state_d = S_START;
        cnt_d = '0;
      end
      S_START: if (cnt_q == MID) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = sync2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        data_d[idx_q] = sync2_q;
        idx_d = idx_q + 3'd1;
`ifdef RS422_UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = S_PARITY;
`else
        if (idx_q == 3'd7) state_d = S_STOP;
`endif
      end
`ifdef RS422_UART_RX_PARITY_EN
      S_PARITY: if (cnt_q == LAST) begin
        cnt_d = '0;
        par_d = sync2_q;
        state_d = S_STOP;
      end
`endif
      S_STOP: if (cnt_q == LAST) begin
        cnt_d = '0;
        if (!sync2_q) begin
          frame_err_d = 1'b1;
          state_d = S_BRK;
        end else begin
          state_d = S_IDLE;
`ifdef RS422_UART_RX_PARITY_EN
          if (par_q ^ (^data_q) ^ (PARITY_ODD != 0)) parity_err_d = 1'b1;
          else begin
            valid_d = 1'b1;
            dout_d = data_q;
          end
`else
          valid_d = 1'b1;
          dout_d = data_q;
`endif
        end
      end
      S_BRK: if (sync2_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q <= 1'b1;
      settle_q <= '0;
      armed_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef RS422_UART_RX_PARITY_EN
      par_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q <= hist_d;
      settle_q <= settle_d;
      armed_q <= armed_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      data_q <= data_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q <= busy_d;
`ifdef RS422_UART_RX_PARITY_EN
      par_q <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end
  assign valid = valid_q;
  assign dout = dout_q;
  assign frame_err = frame_err_q;
  assign busy = busy_q;
`ifdef RS422_UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_rs422_uart_rx.sv
// tb_rs422_uart_rx: scoreboard bench; frames are built from line-level rules and outcomes queued for a monitor.
`timescale 1ns/1ps
module tb_rs422_uart_rx;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int BD = CLK_FREQ / BAUD;
  localparam int PODD = 0;
`ifdef RS422_UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS = PAR_EN ? 11 : 10;
  localparam int LAT = 2 + (2 * NBITS - 1) * BD / 2;
  typedef enum int {K_VALID, K_FERR, K_PERR} kind_t;
  typedef struct {
    kind_t kind;
    logic [7:0] data;
    longint t0;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
  logic valid, frame_err, parity_err, busy;
  logic [7:0] dout;
  exp_t expq[$];
  exp_t mon_e;
  int n_chk = 0, n_pass = 0, seq_cnt = 0, lat;
  logic [7:0] last_good = 8'h00;
  logic [39:0] seq_hist = '0;
  kind_t act_kind;
  rs422_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .valid(valid), .dout(dout),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
  endtask
  function automatic logic exp_par(input logic [7:0] b);
    return (^b) ^ (PODD != 0);
  endfunction
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int gap, input bit cb);
    logic [NBITS-1:0] ln;
    exp_t e;
    ln[0] = 1'b0;
    for (int i = 0; i < 8; i++) ln[i+1] = b[i];
    if (PAR_EN) ln[9] = par;
    ln[NBITS-1] = stp;
    e.kind = !stp ? K_FERR : (PAR_EN && par != exp_par(b)) ? K_PERR : K_VALID;
    e.data = b;
    e.t0 = $time;
    expq.push_back(e);
    for (int i = 0; i < NBITS; i++) begin
      rxd = ln[i];
      repeat (BD) @(negedge clk);
      if (cb && i < NBITS - 1) chk("busy_in_frame", busy, 1);
    end
    rxd = 1'b1;
    repeat (gap * BD) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (rst_n && (valid || frame_err || parity_err)) begin
      chk("strobe_onehot", int'(valid) + int'(frame_err) + int'(parity_err), 1);
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b parity_err=%0b dout=%02h, required no strobe (t=%0t)",
                 valid, frame_err, parity_err, dout, $time);
      end else begin
        mon_e = expq.pop_front();
        act_kind = valid ? K_VALID : frame_err ? K_FERR : K_PERR;
        chk("strobe_kind", act_kind, mon_e.kind);
        lat = int'(($time - mon_e.t0) / 10);
        chk("latency_in_window", (lat >= LAT - 1 && lat <= LAT + 1) ? 1 : 0, 1);
        if (mon_e.kind == K_VALID) begin
          chk("dout", dout, mon_e.data);
          last_good = mon_e.data;
          seq_hist = {seq_hist[31:0], dout};
          if (seq_hist == 40'hAABBCCDDEE) seq_cnt++;
        end else chk("dout_hold", dout, last_good);
      end
    end
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] b;
    logic [7:0] seq [5];
    logic stp;
    int gap;
    seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    repeat (3) @(negedge clk);
    chk("reset_valid", valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_parity_err", parity_err, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hA5, exp_par(8'hA5), 1'b1, 1, 1'b1);
    chk("busy_idle_after_a5", busy, 0);
    chk("dout_a5", dout, 8'hA5);
    for (int i = 0; i < 5; i++) send_frame(seq[i], exp_par(seq[i]), 1'b1, (i == 4) ? 1 : 0, 1'b0);
    chk("seq_detect_once", seq_cnt, 1);
    chk("dout_ee", dout, 8'hEE);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    chk("glitch_busy_high", busy, 1);
    repeat (7) @(negedge clk);
    chk("glitch_busy_low", busy, 0);
    repeat (BD) @(negedge clk);
    send_frame(8'h3C, exp_par(8'h3C), 1'b1, 1, 1'b0);
    chk("dout_3c", dout, 8'h3C);
    send_frame(8'h55, exp_par(8'h55), 1'b0, 0, 1'b0);
    rxd = 1'b0;
    repeat (3 * BD) @(negedge clk);
    chk("break_busy_high", busy, 1);
    chk("break_dout_hold", dout, 8'h3C);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_busy_low", busy, 0);
    repeat (BD) @(negedge clk);
    rxd = 1'b0;
    repeat (BD) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BD + BD / 2) @(negedge clk);
    rst_n = 1'b0;
    last_good = 8'h00;
    @(negedge clk);
    chk("midreset_valid", valid, 0);
    chk("midreset_dout", dout, 0);
    chk("midreset_frame_err", frame_err, 0);
    chk("midreset_parity_err", parity_err, 0);
    chk("midreset_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_busy", busy, 0);
    send_frame(8'h12, exp_par(8'h12), 1'b1, 1, 1'b0);
    chk("dout_12", dout, 8'h12);
`ifdef RS422_UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1, 1'b0);
    chk("parity_good_dout", dout, 8'h07);
    send_frame(8'h07, 1'b0, 1'b1, 1, 1'b0);
`endif
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      stp = ($urandom % 8) != 0;
      gap = stp ? int'($urandom % 3) : 1 + int'($urandom % 2);
      send_frame(b, exp_par(b) ^ (PAR_EN && ($urandom % 6) == 0), stp, gap, 1'b0);
    end
    for (int i = 0; i < 4 * BD && expq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
